ecc_hamming_decoder_pipe: RTL and testbench

- Pipelined Hamming/SECDED decoder; consumes codewords produced by ecc_hamming_encoder with the same D/DW/C/SECDED configuration.
- Computes syndrome, corrects single-bit errors, flags double errors, returns DW data bits.
- Valid/ready streaming on both sides; sits between an ECC-protected storage or link and its consumer.
- Provides saturating single/double error counters and a first-error syndrome log.

---
 rtl/ecc_hamming_decoder_pipe.sv | 169 ++++++++++++++++
 tb/tb_ecc_hamming_decoder_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_hamming_decoder_pipe.sv
// Two-stage pipelined Hamming/SECDED decoder with valid/ready on both sides,
// saturating error counters and a first-error syndrome log.
module ecc_hamming_decoder_pipe #(
    parameter int D      = 4,
    parameter int DW     = D,
    parameter int C      = 7,
    parameter int SECDED = 1,
    parameter int CNT_W  = 8,
    localparam int P     = C - D,
    localparam int CW    = DW + P
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_codeword,
    input  logic             in_extra_parity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_single_err,
    output logic             out_double_err,
    output logic [P-1:0]     out_syndrome,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] err_cnt_single,
    output logic [CNT_W-1:0] err_cnt_double,
    output logic             err_log_valid,
    output logic [P-1:0]     err_log_syndrome
);

    if (P < 2 || DW > D) begin : g_param_check
        $error("ecc_hamming_decoder_pipe: need P >= 2 and DW <= D");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic            s1_valid;
    logic [CW-1:0]   s1_cw;
    logic [P-1:0]    s1_syn;
    logic            s1_op;

    logic            s2_valid;
    logic [DW-1:0]   s2_data;
    logic            s2_single;
    logic            s2_double;
    logic [P-1:0]    s2_syn;

    logic            s1_adv;
    logic            s2_adv;
    logic            xfer;

    logic [P-1:0]    syn_c;
    logic            op_c;
    logic            flip_c;
    logic            single_c;
    logic            double_c;
    logic [CW-1:0]   fixed_c;
    logic [DW-1:0]   data_c;
    int              n_c;

    assign s2_adv   = ~s2_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;
    assign xfer     = s2_valid & out_ready;

    // Padded positions above CW are zero, so they never contribute to the syndrome.
    always_comb begin
        syn_c = '0;
        for (int k = 0; k < P; k++) begin
            for (int j = 1; j <= CW; j++) begin
                if (((j >> k) & 1) == 1) syn_c[k] = syn_c[k] ^ in_codeword[j-1];
            end
        end
        op_c = (^in_codeword) ^ in_extra_parity;
    end

    always_comb begin
        flip_c   = 1'b0;
        single_c = 1'b0;
        double_c = 1'b0;
        if (s1_syn == '0) begin
            single_c = (SECDED != 0) && s1_op;
        end else if ((SECDED != 0) && !s1_op) begin
            double_c = 1'b1;
        end else if (int'(s1_syn) <= CW) begin
            flip_c   = 1'b1;
            single_c = 1'b1;
        end else begin
            // Syndrome points into the padded region: cannot be a real single error.
            double_c = 1'b1;
        end

        fixed_c = s1_cw;
        for (int j = 1; j <= CW; j++) begin
            if (flip_c && int'(s1_syn) == j) fixed_c[j-1] = ~fixed_c[j-1];
        end

        data_c = '0;
        n_c    = 0;
        for (int j = 1; j <= CW; j++) begin
            if ((j & (j - 1)) != 0) begin
                if (n_c < DW) data_c[n_c] = fixed_c[j-1];
                n_c = n_c + 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_syn   <= '0;
            s1_op    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cw  <= in_codeword;
                s1_syn <= syn_c;
                s1_op  <= op_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s2_valid  <= 1'b0;
            s2_data   <= '0;
            s2_single <= 1'b0;
            s2_double <= 1'b0;
            s2_syn    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data   <= data_c;
                s2_single <= single_c;
                s2_double <= double_c;
                s2_syn    <= s1_syn;
            end
        end
    end

    assign out_valid      = s2_valid;
    assign out_data       = s2_data;
    assign out_single_err = s2_single;
    assign out_double_err = s2_double;
    assign out_syndrome   = s2_syn;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            err_cnt_single   <= '0;
            err_cnt_double   <= '0;
            err_log_valid    <= 1'b0;
            err_log_syndrome <= '0;
        end else if (cnt_clear) begin
            err_cnt_single   <= '0;
            err_cnt_double   <= '0;
            err_log_valid    <= 1'b0;
            err_log_syndrome <= '0;
        end else if (xfer) begin
            if (s2_single && err_cnt_single != CNT_MAX) err_cnt_single <= err_cnt_single + 1'b1;
            if (s2_double && err_cnt_double != CNT_MAX) err_cnt_double <= err_cnt_double + 1'b1;
            if ((s2_single || s2_double) && !err_log_valid) begin
                err_log_valid    <= 1'b1;
                err_log_syndrome <= s2_syn;
            end
        end
    end

endmodule

// File: tb/tb_ecc_hamming_decoder_pipe.sv
// Directed bench for the (7,4) SECDED decoder pipe with 2-bit counters so
// saturation is reachable quickly.
module tb_ecc_hamming_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_codeword;
    logic       in_extra_parity;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_single_err;
    logic       out_double_err;
    logic [2:0] out_syndrome;
    logic       cnt_clear;
    logic [1:0] err_cnt_single;
    logic [1:0] err_cnt_double;
    logic       err_log_valid;
    logic [2:0] err_log_syndrome;

    int n_checks = 0;
    int n_errors = 0;

    int exp_cs = 0;
    int exp_cd = 0;
    int exp_lv = 0;
    int exp_ls = 0;

    typedef struct {
        logic [6:0] cw;
        logic       extra;
        logic [3:0] data;
        logic       s;
        logic       d;
        logic [2:0] syn;
    } vec_t;

    vec_t vecs[10];

    ecc_hamming_decoder_pipe #(.D(4), .DW(4), .C(7), .SECDED(1), .CNT_W(2)) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_codeword      (in_codeword),
        .in_extra_parity  (in_extra_parity),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_single_err   (out_single_err),
        .out_double_err   (out_double_err),
        .out_syndrome     (out_syndrome),
        .cnt_clear        (cnt_clear),
        .err_cnt_single   (err_cnt_single),
        .err_cnt_double   (err_cnt_double),
        .err_log_valid    (err_log_valid),
        .err_log_syndrome (err_log_syndrome)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_xfer(input int idx);
        if (vecs[idx].s && exp_cs < 3) exp_cs++;
        if (vecs[idx].d && exp_cd < 3) exp_cd++;
        if ((vecs[idx].s || vecs[idx].d) && exp_lv == 0) begin
            exp_lv = 1;
            exp_ls = int'(vecs[idx].syn);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_cnt_single"}, 32'(err_cnt_single), 32'(exp_cs));
        check({tag, "_cnt_double"}, 32'(err_cnt_double), 32'(exp_cd));
        check({tag, "_log_valid"}, 32'(err_log_valid), 32'(exp_lv));
        check({tag, "_log_syn"}, 32'(err_log_syndrome), 32'(exp_ls));
    endtask

    // One word through an idle pipe with out_ready held high.
    task automatic one_word(input int idx);
        @(negedge clk);
        in_valid        = 1'b1;
        in_codeword     = vecs[idx].cw;
        in_extra_parity = vecs[idx].extra;
        out_ready       = 1'b1;
        #1 check("in_ready_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("latency_1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_2", 32'(out_valid), 32'd1);
        check("data", 32'(out_data), 32'(vecs[idx].data));
        check("single", 32'(out_single_err), 32'(vecs[idx].s));
        check("double", 32'(out_double_err), 32'(vecs[idx].d));
        check("syndrome", 32'(out_syndrome), 32'(vecs[idx].syn));
        @(negedge clk);
        model_xfer(idx);
        check("drained", 32'(out_valid), 32'd0);
        check_counters("seq");
    endtask

    initial begin
        vecs[0] = '{7'b1010101, 1'b0, 4'b1011, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{7'b1000101, 1'b0, 4'b1011, 1'b1, 1'b0, 3'd5};
        vecs[2] = '{7'b1010110, 1'b0, 4'b1011, 1'b0, 1'b1, 3'd3};
        vecs[3] = '{7'b1010101, 1'b1, 4'b1011, 1'b1, 1'b0, 3'd0};
        vecs[4] = '{7'b0110011, 1'b0, 4'b0110, 1'b0, 1'b0, 3'd0};
        vecs[5] = '{7'b1110011, 1'b0, 4'b0110, 1'b1, 1'b0, 3'd7};
        vecs[6] = '{7'b0110111, 1'b0, 4'b0110, 1'b1, 1'b0, 3'd3};
        vecs[7] = '{7'b0110010, 1'b0, 4'b0110, 1'b1, 1'b0, 3'd1};
        vecs[8] = '{7'b0100111, 1'b0, 4'b0101, 1'b0, 1'b1, 3'd6};
        vecs[9] = '{7'b0110011, 1'b1, 4'b0110, 1'b1, 1'b0, 3'd0};

        rst_b = 1'b0;
        in_valid = 1'b0;
        in_codeword = '0;
        in_extra_parity = 1'b0;
        out_ready = 1'b0;
        cnt_clear = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_counters("rst");
        @(negedge clk);
        rst_b = 1'b1;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++) one_word(i);

        // Clear on the same cycle as an error transfer: clear wins.
        @(negedge clk);
        in_valid = 1'b1;
        in_codeword = vecs[1].cw;
        in_extra_parity = vecs[1].extra;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("clr_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        exp_cs = 0; exp_cd = 0; exp_lv = 0; exp_ls = 0;
        check_counters("clr");
        one_word(2);

        // Back-to-back stream with random backpressure.
        begin
            int sent = 0, recv = 0, occ = 0, cyc = 0;
            logic stalled = 1'b0;
            logic [3:0] held = '0;
            while (recv < 10 && cyc < 400) begin
                @(negedge clk);
                cyc++;
                in_valid = (sent < 10);
                if (sent < 10) begin
                    in_codeword = vecs[sent].cw;
                    in_extra_parity = vecs[sent].extra;
                end
                out_ready = 1'($urandom_range(0, 1));
                #1;
                check("bp_in_ready", 32'(in_ready), 32'(!(occ == 2 && !out_ready)));
                if (stalled) begin
                    check("bp_hold_valid", 32'(out_valid), 32'd1);
                    check("bp_hold_data", 32'(out_data), 32'(held));
                end
                if (out_valid && out_ready) begin
                    check("bp_data", 32'(out_data), 32'(vecs[recv].data));
                    check("bp_syn", 32'(out_syndrome), 32'(vecs[recv].syn));
                    model_xfer(recv);
                    recv++;
                    occ--;
                end
                if (in_valid && in_ready) begin
                    sent++;
                    occ++;
                end
                stalled = out_valid && !out_ready;
                held = out_data;
            end
            in_valid = 1'b0;
            check("bp_received", 32'(recv), 32'd10);
            @(negedge clk);
            check_counters("bp");
        end

        // Reset while a word sits in stage 2.
        @(negedge clk);
        in_valid = 1'b1;
        in_codeword = vecs[5].cw;
        in_extra_parity = vecs[5].extra;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_b = 1'b0;
        #1;
        exp_cs = 0; exp_cd = 0; exp_lv = 0; exp_ls = 0;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check_counters("async_rst");
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
